// File: rtl/r_pkg.sv
// Shared constants and state type for the R function stream feeder.
package r_pkg;

  localparam int unsigned R_WIN_W  = 16;
  localparam int unsigned R_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FLUSH
  } r_feed_state_e;

endpackage

// File: rtl/r_stream_feeder.sv
// Byte stream -> 16-bit sliding window for the R function, and R results -> packed bytes.
module r_stream_feeder
  import r_pkg::*;
#(
  parameter int unsigned BYTE_W = R_BYTE_W,
  parameter int unsigned WIN_W  = R_WIN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_last,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [WIN_W-1:0]  func_in,
  input  logic              func_out,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready
);

  localparam int unsigned          CntW   = $clog2(BYTE_W);
  localparam logic [CntW-1:0]      CntMax = CntW'(BYTE_W - 1);

  r_feed_state_e     state_q, state_d;
  logic [BYTE_W-1:0] sh_q, sh_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              ev_valid_q, ev_valid_d;
  // Frame-end flag of the byte whose bits currently sit in the window; last_q may
  // already belong to the next byte by the time its final result is captured.
  logic              ev_last_q, ev_last_d;
  logic [BYTE_W-2:0] pack_q, pack_d;
  logic [CntW-1:0]   pack_cnt_q, pack_cnt_d;
  logic [BYTE_W-1:0] m_data_q, m_data_d;
  logic              m_last_q, m_last_d;
  logic              m_valid_q, m_valid_d;
  logic              last_q, last_d;

  logic stall;
  logic capture;
  logic shift_en;
  logic accept;

  assign stall    = ev_valid_q && (pack_cnt_q == CntMax) && m_valid_q && !m_ready;
  assign capture  = ev_valid_q && !stall;
  assign shift_en = (state_q == SHIFT) && !stall;
  assign s_ready  = !stall && ((state_q == IDLE) ||
                               ((state_q == SHIFT) && (bit_cnt_q == CntMax) && !last_q));
  assign accept   = s_valid && s_ready;

  assign func_in = win_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign m_valid = m_valid_q;

  // Next-state: input FSM, window shifting, result capture and output register.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bit_cnt_d  = bit_cnt_q;
    win_d      = win_q;
    ev_valid_d = ev_valid_q;
    ev_last_d  = ev_last_q;
    pack_d     = pack_q;
    pack_cnt_d = pack_cnt_q;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    m_valid_d  = m_valid_q && !m_ready;
    last_d     = last_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sh_d      = s_data;
          last_d    = s_last;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          win_d     = {win_q[WIN_W-2:0], sh_q[BYTE_W-1]};
          sh_d      = sh_q << 1;
          ev_last_d = last_q;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CntMax) begin
            if (accept) begin
              sh_d      = s_data;
              last_d    = s_last;
              bit_cnt_d = '0;
            end else if (last_q) begin
              state_d = FLUSH;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      FLUSH: begin
        // Final window is evaluated this cycle; clear so the next frame starts from zeros.
        if (!stall) begin
          win_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A window shifted in this edge is fresh; otherwise a capture consumes it.
    if (shift_en) begin
      ev_valid_d = 1'b1;
    end else if (capture) begin
      ev_valid_d = 1'b0;
    end

    if (capture) begin
      if (pack_cnt_q == CntMax) begin
        m_data_d   = {pack_q, func_out};
        m_last_d   = ev_last_q;
        m_valid_d  = 1'b1;
        pack_cnt_d = '0;
      end else begin
        pack_d     = {pack_q[BYTE_W-3:0], func_out};
        pack_cnt_d = pack_cnt_q + 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      win_q      <= '0;
      ev_valid_q <= 1'b0;
      ev_last_q  <= 1'b0;
      pack_q     <= '0;
      pack_cnt_q <= '0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      m_valid_q  <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      win_q      <= win_d;
      ev_valid_q <= ev_valid_d;
      ev_last_q  <= ev_last_d;
      pack_q     <= pack_d;
      pack_cnt_q <= pack_cnt_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      m_valid_q  <= m_valid_d;
      last_q     <= last_d;
    end
  end

endmodule

// File: tb/tb_r_stream_feeder.sv
// Self-checking bench for r_stream_feeder with a bench-side R function and frame model.
module tb_r_stream_feeder;
  import r_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_last;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] func_in;
  logic        func_out;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_valid;
  logic        m_ready = 1'b1;

  int vectors     = 0;
  int miscompares = 0;
  int func_mode   = 0;  // 0: constant 1, 1: echo func_in[0], 2: hashed R
  int rdy_mode    = 1;  // 0: hold off, 1: always ready, 2: random
  int cyc         = 0;
  int mv_seen     = 0;
  logic mv_prev   = 1'b0;

  out_t       exp_q[$];
  out_t       got_q[$];
  int         acc_q[$];
  int         rise_q[$];
  logic [7:0] frame_q[$];

  r_stream_feeder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_last   (s_last),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .func_in  (func_in),
    .func_out (func_out),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready)
  );

  always #5 clk = ~clk;

  function automatic logic r_ref(input logic [15:0] w);
    return (^(w & 16'hA53B)) ^ (w[15] & w[2]);
  endfunction

  function automatic logic r_eval(input int mode, input logic [15:0] w);
    if (mode == 0) return 1'b1;
    if (mode == 1) return w[0];
    return r_ref(w);
  endfunction

  assign func_out = r_eval(func_mode, func_in);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected output bytes of frame_q: every bit of the stream, MSB first, is pushed
  // into a zero-initialised 16-bit window and R is evaluated once per position.
  task automatic model_frame();
    logic [15:0] w;
    logic [7:0]  b;
    logic [7:0]  acc;
    out_t        o;
    w   = '0;
    acc = '0;
    for (int i = 0; i < frame_q.size(); i++) begin
      b = frame_q[i];
      for (int j = 7; j >= 0; j--) begin
        w   = {w[14:0], b[j]};
        acc = {acc[6:0], r_eval(func_mode, w)};
      end
      o.d = acc;
      o.l = (i == frame_q.size() - 1);
      exp_q.push_back(o);
    end
  endtask

  // Present one byte and return #1 after the edge that accepts it.
  task automatic send(input logic [7:0] d, input logic l);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    while (!ok && n < 2000) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic send_frame();
    model_frame();
    for (int i = 0; i < frame_q.size(); i++) begin
      send(frame_q[i], i == frame_q.size() - 1);
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", {31'd0, n < 5000}, 32'd1);
  endtask

  task automatic clear_logs();
    got_q.delete();
    acc_q.delete();
    rise_q.delete();
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) m_ready = 1'b0;
    else if (rdy_mode == 1) m_ready = 1'b1;
    else m_ready = 1'($urandom_range(0, 1));
  end

  // Compare process: every output handshake is checked against the model queue.
  always @(negedge clk) begin
    out_t e;
    out_t g;
    if (rst_n) begin
      if (s_valid && s_ready) acc_q.push_back(cyc);
      if (m_valid && !mv_prev) rise_q.push_back(cyc);
      if (m_valid) mv_seen++;
      if (m_valid && m_ready) begin
        g.d = m_data;
        g.l = m_last;
        got_q.push_back(g);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_out: got %0h last %0b, expected no output", m_data, m_last);
        end else begin
          e = exp_q.pop_front();
          check("m_data", {24'd0, m_data}, {24'd0, e.d});
          check("m_last", {31'd0, m_last}, {31'd0, e.l});
        end
      end
    end
    mv_prev = m_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    check("rst_func_in", {16'd0, func_in}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);
    check("rst_m_last", {31'd0, m_last}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Constant-1 R: single-byte frame gives 8'hFF, 9 cycles after acceptance.
    func_mode = 0;
    clear_logs();
    frame_q = '{8'hA5};
    send_frame();
    wait_drain();
    check("t1_count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      check("t1_data", {24'd0, got_q[0].d}, 32'hFF);
      check("t1_last", {31'd0, got_q[0].l}, 32'd1);
    end
    if (acc_q.size() > 0 && rise_q.size() > 0) check("t1_latency", rise_q[0] - acc_q[0], 10);
    else check("t1_latency_seen", 0, 1);

    // Echo R: stream passes through; window holds the last two bytes; no input bubbles.
    func_mode = 1;
    clear_logs();
    frame_q = '{8'h12, 8'h34, 8'h56};
    model_frame();
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    send(8'h56, 1'b1);
    check("t2_window", {16'd0, func_in}, 32'h1234);
    s_valid = 1'b0;
    wait_drain();
    check("t2_window_flushed", {16'd0, func_in}, 32'h0);
    check("t2_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("t2_byte0", {23'd0, got_q[0]}, {23'd0, 8'h12, 1'b0});
      check("t2_byte1", {23'd0, got_q[1]}, {23'd0, 8'h34, 1'b0});
      check("t2_byte2", {23'd0, got_q[2]}, {23'd0, 8'h56, 1'b1});
    end
    if (acc_q.size() == 3) begin
      check("t2_gap01", acc_q[1] - acc_q[0], 8);
      check("t2_gap12", acc_q[2] - acc_q[1], 8);
    end else check("t2_accepts", acc_q.size(), 3);

    // Backpressure: second byte's final capture stalls, window frozen at 16'h3CC3.
    rdy_mode = 0;
    @(posedge clk);
    #2;
    clear_logs();
    frame_q = '{8'h3C, 8'hC3};
    send_frame();
    repeat (20) @(posedge clk);
    #1;
    check("t3_frozen_win", {16'd0, func_in}, 32'h3CC3);
    check("t3_held_valid", {31'd0, m_valid}, 32'd1);
    check("t3_held_data", {24'd0, m_data}, 32'h3C);
    check("t3_s_ready", {31'd0, s_ready}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("t3_still_frozen", {16'd0, func_in}, 32'h3CC3);
    rdy_mode = 1;
    wait_drain();
    check("t3_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t3_byte0", {23'd0, got_q[0]}, {23'd0, 8'h3C, 1'b0});
      check("t3_byte1", {23'd0, got_q[1]}, {23'd0, 8'hC3, 1'b1});
    end

    // Hashed R over a random 64-byte frame with random downstream readiness.
    func_mode = 2;
    rdy_mode  = 2;
    clear_logs();
    frame_q.delete();
    for (int i = 0; i < 64; i++) frame_q.push_back(8'($urandom));
    send_frame();
    wait_drain();
    check("t4_count", got_q.size(), 64);
    rdy_mode = 1;

    // Reset mid-byte: outputs return to reset values, partial results are dropped.
    func_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    send(8'hAA, 1'b0);
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_s_ready", {31'd0, s_ready}, 32'd1);
    check("mid_rst_func_in", {16'd0, func_in}, 32'd0);
    check("mid_rst_m_data", {24'd0, m_data}, 32'd0);
    check("mid_rst_m_last", {31'd0, m_last}, 32'd0);
    check("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    mv_seen = 0;
    repeat (20) @(posedge clk);
    #1;
    check("no_valid_after_rst", mv_seen, 0);
    clear_logs();
    frame_q = '{8'h5A};
    send_frame();
    wait_drain();
    check("t5_count", got_q.size(), 1);
    if (got_q.size() > 0) check("t5_byte", {23'd0, got_q[0]}, {23'd0, 8'h5A, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
